decode_stage: RTL and testbench

Second stage of the multi-cycle core; it sits directly after instruction fetch. On a one-cycle `enable` pulse, which is fetch's completion pulse, it latches the 32-bit RV32I instruction word and its PC. It then reads both source operands from the synchronous register file and produces registered operands, a sign-extended immediate, an operation ID and control flags. It pulses `done` for one cycle so the execute stage can start.

---
 rtl/decode_stage.sv | 259 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: latches one instruction from fetch, decodes it and
// collects both source operands from the synchronous register file.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic [31:0] command_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic        done_o,
  output logic        busy_o,
  output logic [31:0] pc_out_o,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  output logic [31:0] src1_o,
  output logic [31:0] src2_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] imm_o,
  output logic [5:0]  op_o,
  output logic        writes_rd_o,
  output logic        is_load_o,
  output logic        is_store_o,
  output logic        is_branch_o,
  output logic        is_jump_o,
  output logic        illegal_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    READ = 2'd2
  } state_e;

  localparam logic [5:0] OpIllegal = 6'd63;

  state_e      state_q, state_d;
  logic        done_q;
  logic [31:0] pcOut_q, src1_q, src2_q, imm_q;
  logic [4:0]  rs1Addr_q, rs2Addr_q, rdAddr_q;
  logic [5:0]  op_q;
  logic        writesRd_q, isLoad_q, isStore_q, isBranch_q, isJump_q, illegal_q;

  logic        accept;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] immI, immS, immB, immU, immJ;
  logic [5:0]  decOp;
  logic [31:0] decImm;
  logic        decLegal, decWrites, decLoad, decStore, decBranch, decJump;

  assign opcode = command_i[6:0];
  assign funct3 = command_i[14:12];
  assign funct7 = command_i[31:25];

  assign immI = {{20{command_i[31]}}, command_i[31:20]};
  assign immS = {{20{command_i[31]}}, command_i[31:25], command_i[11:7]};
  assign immB = {{19{command_i[31]}}, command_i[31], command_i[7],
                 command_i[30:25], command_i[11:8], 1'b0};
  assign immU = {command_i[31:12], 12'h000};
  assign immJ = {{11{command_i[31]}}, command_i[31], command_i[19:12],
                 command_i[20], command_i[30:21], 1'b0};

  // The done cycle counts as busy, so the FSM can already sit in IDLE without
  // letting an enable in that same cycle through.
  assign busy_o = (state_q != IDLE) || done_q;
  assign accept = enable_i && !busy_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ADDR;
      ADDR:    state_d = READ;
      READ:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    decOp     = OpIllegal;
    decImm    = '0;
    decLegal  = 1'b0;
    decWrites = 1'b0;
    decLoad   = 1'b0;
    decStore  = 1'b0;
    decBranch = 1'b0;
    decJump   = 1'b0;
    case (opcode)
      7'b0110111: begin
        decLegal = 1'b1; decOp = 6'd0; decImm = immU; decWrites = 1'b1;
      end
      7'b0010111: begin
        decLegal = 1'b1; decOp = 6'd1; decImm = immU; decWrites = 1'b1;
      end
      7'b1101111: begin
        decLegal = 1'b1; decOp = 6'd2; decImm = immJ; decWrites = 1'b1;
        decJump  = 1'b1;
      end
      7'b1100111: begin
        decLegal = (funct3 == 3'b000); decOp = 6'd3; decImm = immI;
        decWrites = 1'b1; decJump = 1'b1;
      end
      7'b1100011: begin
        decLegal = 1'b1; decImm = immB; decBranch = 1'b1;
        case (funct3)
          3'b000:  decOp = 6'd4;
          3'b001:  decOp = 6'd5;
          3'b100:  decOp = 6'd6;
          3'b101:  decOp = 6'd7;
          3'b110:  decOp = 6'd8;
          3'b111:  decOp = 6'd9;
          default: decLegal = 1'b0;
        endcase
      end
      7'b0000011: begin
        decLegal = 1'b1; decImm = immI; decLoad = 1'b1; decWrites = 1'b1;
        case (funct3)
          3'b000:  decOp = 6'd10;
          3'b001:  decOp = 6'd11;
          3'b010:  decOp = 6'd12;
          3'b100:  decOp = 6'd13;
          3'b101:  decOp = 6'd14;
          default: decLegal = 1'b0;
        endcase
      end
      7'b0100011: begin
        decLegal = 1'b1; decImm = immS; decStore = 1'b1;
        case (funct3)
          3'b000:  decOp = 6'd15;
          3'b001:  decOp = 6'd16;
          3'b010:  decOp = 6'd17;
          default: decLegal = 1'b0;
        endcase
      end
      7'b0010011: begin
        decLegal = 1'b1; decImm = immI; decWrites = 1'b1;
        case (funct3)
          3'b000: decOp = 6'd18;
          3'b010: decOp = 6'd19;
          3'b011: decOp = 6'd20;
          3'b100: decOp = 6'd21;
          3'b110: decOp = 6'd22;
          3'b111: decOp = 6'd23;
          3'b001: begin
            decOp = 6'd24; decLegal = (funct7 == 7'b0000000);
          end
          3'b101: begin
            if (funct7 == 7'b0000000)      decOp = 6'd25;
            else if (funct7 == 7'b0100000) decOp = 6'd26;
            else                           decLegal = 1'b0;
          end
          default: decLegal = 1'b0;
        endcase
      end
      7'b0110011: begin
        decLegal = 1'b1; decWrites = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  decOp = 6'd27;
            3'b001:  decOp = 6'd29;
            3'b010:  decOp = 6'd30;
            3'b011:  decOp = 6'd31;
            3'b100:  decOp = 6'd32;
            3'b101:  decOp = 6'd33;
            3'b110:  decOp = 6'd35;
            default: decOp = 6'd36;
          endcase
        end else if (funct7 == 7'b0100000) begin
          case (funct3)
            3'b000:  decOp = 6'd28;
            3'b101:  decOp = 6'd34;
            default: decLegal = 1'b0;
          endcase
        end else begin
          decLegal = 1'b0;
        end
      end
      default: decLegal = 1'b0;
    endcase

    // An illegal word must not leak any partial decode into execute.
    if (!decLegal) begin
      decOp     = OpIllegal;
      decImm    = '0;
      decWrites = 1'b0;
      decLoad   = 1'b0;
      decStore  = 1'b0;
      decBranch = 1'b0;
      decJump   = 1'b0;
    end
    if (command_i[11:7] == 5'd0) decWrites = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q     <= 1'b0;
      pcOut_q    <= '0;
      rs1Addr_q  <= '0;
      rs2Addr_q  <= '0;
      rdAddr_q   <= '0;
      op_q       <= OpIllegal;
      imm_q      <= '0;
      writesRd_q <= 1'b0;
      isLoad_q   <= 1'b0;
      isStore_q  <= 1'b0;
      isBranch_q <= 1'b0;
      isJump_q   <= 1'b0;
      illegal_q  <= 1'b0;
      src1_q     <= '0;
      src2_q     <= '0;
    end else begin
      done_q <= (state_q == READ);
      if (accept) begin
        pcOut_q    <= pc_i;
        rs1Addr_q  <= command_i[19:15];
        rs2Addr_q  <= command_i[24:20];
        rdAddr_q   <= command_i[11:7];
        op_q       <= decOp;
        imm_q      <= decImm;
        writesRd_q <= decWrites;
        isLoad_q   <= decLoad;
        isStore_q  <= decStore;
        isBranch_q <= decBranch;
        isJump_q   <= decJump;
        illegal_q  <= !decLegal;
      end
      // x0 is hardwired to zero regardless of what the register file returns.
      if (state_q == READ) begin
        src1_q <= (rs1Addr_q == 5'd0) ? 32'd0 : rs1_data_i;
        src2_q <= (rs2Addr_q == 5'd0) ? 32'd0 : rs2_data_i;
      end
    end
  end

  assign done_o      = done_q;
  assign pc_out_o    = pcOut_q;
  assign rs1_addr_o  = rs1Addr_q;
  assign rs2_addr_o  = rs2Addr_q;
  assign rd_addr_o   = rdAddr_q;
  assign src1_o      = src1_q;
  assign src2_o      = src2_q;
  assign imm_o       = imm_q;
  assign op_o        = op_q;
  assign writes_rd_o = writesRd_q;
  assign is_load_o   = isLoad_q;
  assign is_store_o  = isStore_q;
  assign is_branch_o = isBranch_q;
  assign is_jump_o   = isJump_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases plus random instructions checked
// against a table-driven RV32I decode model and a synchronous register file.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [31:0] command, pc, rs1Data, rs2Data;
  logic        done, busy;
  logic [31:0] pcOut, src1, src2, imm;
  logic [4:0]  rs1Addr, rs2Addr, rdAddr;
  logic [5:0]  op;
  logic        writesRd, isLoad, isStore, isBranch, isJump, illegal;

  int testCount = 0;
  int failCount = 0;

  logic [31:0] regs [32];

  typedef struct {
    logic [6:0] opc;
    int         f3;
    int         f7;
    int         op;
    byte        fmt;
  } rule_t;

  typedef struct {
    int          op;
    logic [31:0] imm;
    bit          wr, ld, st, br, jp, ill;
  } exp_t;

  rule_t rules[$];

  decode_stage dut (
    .clk        (clk),
    .rst        (rst),
    .enable_i   (enable),
    .command_i  (command),
    .pc_i       (pc),
    .rs1_data_i (rs1Data),
    .rs2_data_i (rs2Data),
    .done_o     (done),
    .busy_o     (busy),
    .pc_out_o   (pcOut),
    .rs1_addr_o (rs1Addr),
    .rs2_addr_o (rs2Addr),
    .src1_o     (src1),
    .src2_o     (src2),
    .rd_addr_o  (rdAddr),
    .imm_o      (imm),
    .op_o       (op),
    .writes_rd_o(writesRd),
    .is_load_o  (isLoad),
    .is_store_o (isStore),
    .is_branch_o(isBranch),
    .is_jump_o  (isJump),
    .illegal_o  (illegal)
  );

  always #5 clk = ~clk;

  // Synchronous-read register file model; x0 is deliberately not forced to 0.
  always @(posedge clk) begin
    rs1Data <= regs[rs1Addr];
    rs2Data <= regs[rs2Addr];
  end

  task automatic addRule(input logic [6:0] opc, input int f3, input int f7,
                         input int opId, input byte fmt);
    rule_t r;
    r.opc = opc; r.f3 = f3; r.f7 = f7; r.op = opId; r.fmt = fmt;
    rules.push_back(r);
  endtask

  task automatic buildRules();
    int bf[6]  = '{0, 1, 4, 5, 6, 7};
    int lf[5]  = '{0, 1, 2, 4, 5};
    int af[6]  = '{0, 2, 3, 4, 6, 7};
    int rf3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int rf7[10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
    addRule(7'h37, -1, -1, 0, "U");
    addRule(7'h17, -1, -1, 1, "U");
    addRule(7'h6F, -1, -1, 2, "J");
    addRule(7'h67,  0, -1, 3, "I");
    for (int i = 0; i < 6; i++)  addRule(7'h63, bf[i], -1, 4 + i, "B");
    for (int i = 0; i < 5; i++)  addRule(7'h03, lf[i], -1, 10 + i, "I");
    for (int i = 0; i < 3; i++)  addRule(7'h23, i, -1, 15 + i, "S");
    for (int i = 0; i < 6; i++)  addRule(7'h13, af[i], -1, 18 + i, "I");
    addRule(7'h13, 1, 0, 24, "I");
    addRule(7'h13, 5, 0, 25, "I");
    addRule(7'h13, 5, 32, 26, "I");
    for (int i = 0; i < 10; i++) addRule(7'h33, rf3[i], rf7[i], 27 + i, "R");
  endtask

  function automatic logic [31:0] immOf(input logic [31:0] c, input byte fmt);
    int v;
    v = 0;
    case (fmt)
      "I": begin v = {20'd0, c[31:20]}; if (c[31]) v -= 4096; end
      "S": begin v = {20'd0, c[31:25], c[11:7]}; if (c[31]) v -= 4096; end
      "B": begin
        v = 2 * {28'd0, c[11:8]} + 32 * {26'd0, c[30:25]} + 2048 * {31'd0, c[7]};
        if (c[31]) v -= 4096;
      end
      "U": v = c & 32'hFFFFF000;
      "J": begin
        v = 2 * {22'd0, c[30:21]} + 2048 * {31'd0, c[20]} + 4096 * {24'd0, c[19:12]};
        if (c[31]) v -= 1048576;
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic exp_t model(input logic [31:0] c);
    exp_t e;
    e.op = 63; e.imm = 32'd0; e.ill = 1'b1;
    e.wr = 1'b0; e.ld = 1'b0; e.st = 1'b0; e.br = 1'b0; e.jp = 1'b0;
    foreach (rules[i]) begin
      if (rules[i].opc == c[6:0] &&
          (rules[i].f3 < 0 || rules[i].f3 == {29'd0, c[14:12]}) &&
          (rules[i].f7 < 0 || rules[i].f7 == {25'd0, c[31:25]})) begin
        e.ill = 1'b0;
        e.op  = rules[i].op;
        e.imm = immOf(c, rules[i].fmt);
      end
    end
    if (!e.ill) begin
      e.jp = (e.op == 2 || e.op == 3);
      e.br = (e.op >= 4 && e.op <= 9);
      e.ld = (e.op >= 10 && e.op <= 14);
      e.st = (e.op >= 15 && e.op <= 17);
      e.wr = !(e.br || e.st) && (c[11:7] != 5'd0);
    end
    return e;
  endfunction

  function automatic logic [31:0] randomInstr();
    logic [6:0]  opcs [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    logic [31:0] w;
    int          sel;
    w   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 9) w[6:0] = opcs[sel];
    if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_done"},  {31'd0, done},     32'd0);
    checkOutput({pfx, "_busy"},  {31'd0, busy},     32'd0);
    checkOutput({pfx, "_op"},    {26'd0, op},       32'd63);
    checkOutput({pfx, "_pc"},    pcOut,             32'd0);
    checkOutput({pfx, "_src1"},  src1,              32'd0);
    checkOutput({pfx, "_src2"},  src2,              32'd0);
    checkOutput({pfx, "_imm"},   imm,               32'd0);
    checkOutput({pfx, "_addrs"}, {17'd0, rs1Addr, rs2Addr, rdAddr}, 32'd0);
    checkOutput({pfx, "_flags"},
                {26'd0, writesRd, isLoad, isStore, isBranch, isJump, illegal}, 32'd0);
  endtask

  task automatic checkDecode(input string pfx, input logic [31:0] cmd,
                             input logic [31:0] pcv, input exp_t e);
    checkOutput({pfx, "_pc"},  pcOut, pcv);
    checkOutput({pfx, "_rs1"}, {27'd0, rs1Addr}, {27'd0, cmd[19:15]});
    checkOutput({pfx, "_rs2"}, {27'd0, rs2Addr}, {27'd0, cmd[24:20]});
    checkOutput({pfx, "_rd"},  {27'd0, rdAddr},  {27'd0, cmd[11:7]});
    checkOutput({pfx, "_op"},  {26'd0, op},      e.op);
    if (!e.ill) checkOutput({pfx, "_imm"}, imm, e.imm);
    checkOutput({pfx, "_flags"},
                {26'd0, writesRd, isLoad, isStore, isBranch, isJump, illegal},
                {26'd0, e.wr, e.ld, e.st, e.br, e.jp, e.ill});
  endtask

  // Called at a negedge; holds enable for one cycle and returns at N+1.
  task automatic applyStimulus(input logic [31:0] cmd, input logic [31:0] pcv);
    enable  = 1'b1;
    command = cmd;
    pc      = pcv;
    @(negedge clk);
    enable  = 1'b0;
    command = $urandom;
    pc      = $urandom;
  endtask

  task automatic runTxn(input string pfx, input logic [31:0] cmd, input logic [31:0] pcv);
    exp_t        e;
    logic [31:0] s1, s2;
    e  = model(cmd);
    s1 = (cmd[19:15] == 5'd0) ? 32'd0 : regs[cmd[19:15]];
    s2 = (cmd[24:20] == 5'd0) ? 32'd0 : regs[cmd[24:20]];
    applyStimulus(cmd, pcv);
    checkOutput({pfx, "_busy_n1"}, {31'd0, busy}, 32'd1);
    checkOutput({pfx, "_done_n1"}, {31'd0, done}, 32'd0);
    checkDecode({pfx, "_n1"}, cmd, pcv, e);
    @(negedge clk);
    checkOutput({pfx, "_done_n2"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    checkOutput({pfx, "_done_n3"}, {31'd0, done}, 32'd1);
    checkOutput({pfx, "_busy_n3"}, {31'd0, busy}, 32'd1);
    checkOutput({pfx, "_src1"}, src1, s1);
    checkOutput({pfx, "_src2"}, src2, s2);
    @(negedge clk);
    checkOutput({pfx, "_done_n4"}, {31'd0, done}, 32'd0);
    checkOutput({pfx, "_busy_n4"}, {31'd0, busy}, 32'd0);
    checkDecode({pfx, "_hold"}, cmd, pcv, e);
  endtask

  initial begin
    exp_t eA;
    rst = 1'b1; enable = 1'b0; command = 32'd0; pc = 32'd0;
    for (int r = 0; r < 32; r++) regs[r] = 32'd0;
    buildRules();
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    @(negedge clk);

    // ADDI x1,x2,-1 with x2 = 5
    regs[2] = 32'd5;
    runTxn("addi", 32'hFFF10093, 32'h0000_0100);
    checkOutput("addi_src1_k",  src1, 32'd5);
    checkOutput("addi_imm_k",   imm, 32'hFFFF_FFFF);
    checkOutput("addi_op_k",    {26'd0, op}, 32'd18);
    checkOutput("addi_rd_k",    {27'd0, rdAddr}, 32'd1);
    checkOutput("addi_wr_k",    {31'd0, writesRd}, 32'd1);

    // SW x3,8(x2)
    regs[2] = 32'h100; regs[3] = 32'hAB;
    runTxn("sw", 32'h00312423, 32'h0000_0104);
    checkOutput("sw_src1_k",  src1, 32'h100);
    checkOutput("sw_src2_k",  src2, 32'hAB);
    checkOutput("sw_imm_k",   imm, 32'd8);
    checkOutput("sw_op_k",    {26'd0, op}, 32'd17);
    checkOutput("sw_store_k", {31'd0, isStore}, 32'd1);
    checkOutput("sw_wr_k",    {31'd0, writesRd}, 32'd0);

    // ADD x1,x0,x0 while the register file returns garbage everywhere
    for (int r = 0; r < 32; r++) regs[r] = 32'hDEADBEEF;
    runTxn("addx0", 32'h000000B3, 32'h0000_0108);
    checkOutput("addx0_src1_k", src1, 32'd0);
    checkOutput("addx0_src2_k", src2, 32'd0);
    checkOutput("addx0_op_k",   {26'd0, op}, 32'd27);

    runTxn("allones", 32'hFFFFFFFF, 32'h0000_010C);
    checkOutput("allones_ill_k", {31'd0, illegal}, 32'd1);
    checkOutput("allones_op_k",  {26'd0, op}, 32'd63);
    checkOutput("allones_flags_k", {27'd0, writesRd, isLoad, isStore, isBranch, isJump}, 32'd0);

    // Enables at N+1..N+3 are ignored; N+4 is accepted
    regs[2] = 32'd5;
    eA = model(32'hFFF10093);
    applyStimulus(32'hFFF10093, 32'h0000_1000);
    enable = 1'b1; command = 32'h00312423; pc = 32'h0000_2000;
    @(negedge clk);
    pc = 32'h0000_2004;
    @(negedge clk);
    pc = 32'h0000_2008;
    checkOutput("b2b_done_n3", {31'd0, done}, 32'd1);
    checkOutput("b2b_pc_n3",   pcOut, 32'h0000_1000);
    @(negedge clk);
    enable = 1'b0;
    checkOutput("b2b_pc_n4",   pcOut, 32'h0000_1000);
    checkOutput("b2b_op_n4",   {26'd0, op}, eA.op);
    checkOutput("b2b_busy_n4", {31'd0, busy}, 32'd0);
    regs[2] = 32'h100; regs[3] = 32'hAB;
    runTxn("b2b_next", 32'h00312423, 32'h0000_3000);

    // Reset pulsed at N+2
    applyStimulus(32'hFFF10093, 32'h0000_4000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetValues("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("midrst_nodone", {31'd0, done}, 32'd0);
    end
    regs[2] = 32'd5;
    runTxn("after_rst", 32'hFFF10093, 32'h0000_5000);

    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < 32; r++) regs[r] = $urandom;
      runTxn($sformatf("rand%0d", t), randomInstr(), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
